// File: rtl/trace_pkg.sv
// Shared types for the retire tracer: entry layout, event kinds and FSM encoding.
package trace_pkg;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  localparam int TRACE_W  = 97;
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 32;
  localparam int PC_LSB   = 64;
  localparam int KIND_BIT = 96;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [TRACE_W-1:0] pack_entry(input logic        kind,
                                                    input logic [31:0] pc,
                                                    input logic [31:0] addr,
                                                    input logic [31:0] data);
    return {kind, pc, addr, data};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Dual-push, single-pop FWFT FIFO; port 0 is written ahead of port 1 in the same edge.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push0,
  input  logic [TRACE_W-1:0]           din0,
  input  logic                         push1,
  input  logic [TRACE_W-1:0]           din1,
  input  logic                         pop,
  output logic [TRACE_W-1:0]           dout,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TRACE_W-1:0] mem_q [DEPTH];
  logic [TRACE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [AW-1:0]      wr_idx1;

  always_comb begin
    mem_d    = mem_q;
    // Port 1 lands behind port 0 only when port 0 also pushes.
    wr_idx1  = wr_ptr_q + AW'(push0);
    wr_ptr_d = wr_ptr_q + AW'(push0) + AW'(push1);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    if (push0) begin
      mem_d[wr_ptr_q] = din0;
    end
    if (push1) begin
      mem_d[wr_idx1] = din1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/retire_tracer.sv
// Captures GRF writes (W) and DM stores (M) into an ordered trace stream and signals end of program.
// Optional macro RETIRE_TRACER_DISPLAY_EN prints each popped entry in simulation.
module retire_tracer
  import trace_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter logic [31:0] END_ADDR     = 32'h0000_4000,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_pc,
  input  logic        grf_we,
  input  logic [31:0] grf_pc,
  input  logic [4:0]  grf_addr,
  input  logic [31:0] grf_wd,
  input  logic        dm_we,
  input  logic [31:0] dm_pc,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wd,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic        trace_kind,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        stall,
  output logic        done
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int DCW = $clog2(DRAIN_CYCLES) + 1;

  state_e             state_q, state_d;
  logic [DCW-1:0]     drain_q, drain_d;
  logic [CW-1:0]      count;
  logic               accept, grf_ev, dm_ev, push0, push1, pop, end_hit;
  logic [TRACE_W-1:0] grf_entry, dm_entry, din0, head;

  // Stall comes from the registered count only, so events never loop back into it.
  assign stall   = (count > CW'(DEPTH - 2)) && (state_q != ST_DONE);
  assign accept  = !stall && (state_q != ST_DONE);
  assign grf_ev  = grf_we && (grf_addr != 5'd0) && accept;
  assign dm_ev   = dm_we && accept;
  assign end_hit = (fetch_pc + 32'd4) >= END_ADDR;

  assign grf_entry = pack_entry(KIND_GRF, grf_pc, {27'd0, grf_addr}, grf_wd);
  assign dm_entry  = pack_entry(KIND_DM, dm_pc, dm_addr, dm_wd);

  assign push0 = grf_ev || dm_ev;
  assign din0  = grf_ev ? grf_entry : dm_entry;
  assign push1 = grf_ev && dm_ev;

  assign trace_valid = (count != CW'(0));
  assign pop         = trace_valid && trace_ready;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push0 (push0),
    .din0  (din0),
    .push1 (push1),
    .din1  (dm_entry),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  assign trace_kind = head[KIND_BIT];
  assign trace_pc   = head[PC_LSB +: 32];
  assign trace_addr = head[ADDR_LSB +: 32];
  assign trace_data = head[DATA_LSB +: 32];
  assign done       = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_RUN: begin
        if (end_hit) begin
          state_d = ST_DRAIN;
          drain_d = DCW'(DRAIN_CYCLES - 1);
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Finish only once nothing is queued and nothing is arriving this edge.
        if ((drain_q == DCW'(0)) && (count == CW'(0)) && !push0) begin
          state_d = ST_DONE;
        end else if (!stall && (drain_q != DCW'(0))) begin
          drain_d = drain_q - DCW'(1);
        end else begin
          drain_d = drain_q;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

`ifdef RETIRE_TRACER_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (!reset && pop) begin
      if (trace_kind == KIND_GRF) begin
        $display("%0t @%h: $%d <= %h", $time, trace_pc, trace_addr[4:0], trace_data);
      end else begin
        $display("%0t @%h: *%h <= %h", $time, trace_pc, trace_addr, trace_data);
      end
    end
  end
`endif

endmodule

// File: tb/tb_retire_tracer.sv
// Directed scoreboard bench for retire_tracer: expected entries queued on drive, compared on pop.
module tb_retire_tracer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        grf_we;
  logic [31:0] grf_pc;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wd;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic        trace_valid;
  logic        trace_ready;
  logic        trace_kind;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        stall;
  logic        done;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t sbq[$];
  int   mstate = 0;
  int   mdrain = 0;
  int   checks = 0;
  int   failures = 0;

  retire_tracer dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_pc    (fetch_pc),
    .grf_we      (grf_we),
    .grf_pc      (grf_pc),
    .grf_addr    (grf_addr),
    .grf_wd      (grf_wd),
    .dm_we       (dm_we),
    .dm_pc       (dm_pc),
    .dm_addr     (dm_addr),
    .dm_wd       (dm_wd),
    .trace_valid (trace_valid),
    .trace_ready (trace_ready),
    .trace_kind  (trace_kind),
    .trace_pc    (trace_pc),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .stall       (stall),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk(input logic kind, input logic [31:0] pc,
                              input logic [31:0] addr, input logic [31:0] data);
    ent_t e;
    e.kind = kind;
    e.pc   = pc;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

  // Compare outputs at the negedge, update the model, then advance one cycle.
  task automatic tick();
    int   cnt;
    bit   exp_stall, pop_now, g_ev, d_ev;
    ent_t h;
    @(negedge clk);
    cnt       = sbq.size();
    exp_stall = (cnt > DEPTH - 2) && (mstate != 2);
    check("stall", stall, exp_stall);
    check("valid", trace_valid, cnt != 0);
    check("done", done, mstate == 2);
    pop_now = (cnt != 0) && trace_ready;
    if (cnt != 0) begin
      h = sbq[0];
      check("kind", trace_kind, h.kind);
      check("pc", trace_pc, h.pc);
      check("addr", trace_addr, h.addr);
      check("data", trace_data, h.data);
    end
    if (reset) begin
      sbq.delete();
      mstate = 0;
      mdrain = 0;
    end else begin
      g_ev = grf_we && (grf_addr != 5'd0) && !exp_stall && (mstate != 2);
      d_ev = dm_we && !exp_stall && (mstate != 2);
      if (pop_now) void'(sbq.pop_front());
      if (g_ev) sbq.push_back(mk(1'b0, grf_pc, {27'd0, grf_addr}, grf_wd));
      if (d_ev) sbq.push_back(mk(1'b1, dm_pc, dm_addr, dm_wd));
      if (mstate == 0) begin
        if (fetch_pc + 32'd4 >= 32'h0000_4000) begin
          mstate = 1;
          mdrain = 3;
        end
      end else if (mstate == 1) begin
        if (mdrain == 0 && cnt == 0 && !(g_ev || d_ev)) mstate = 2;
        else if (!exp_stall && mdrain != 0) mdrain--;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    grf_we = 1'b0;
    dm_we  = 1'b0;
  endtask

  task automatic drive_grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
    grf_we = 1'b1; grf_pc = pc; grf_addr = a; grf_wd = d;
  endtask

  task automatic drive_dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
    dm_we = 1'b1; dm_pc = pc; dm_addr = a; dm_wd = d;
  endtask

  initial begin
    int n;
    int guard;
    reset = 1'b1; fetch_pc = 32'h0; trace_ready = 1'b1;
    grf_we = 1'b0; grf_pc = 32'h0; grf_addr = 5'd0; grf_wd = 32'h0;
    dm_we = 1'b0; dm_pc = 32'h0; dm_addr = 32'h0; dm_wd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    tick();
    check("rst_valid", trace_valid, 32'd0);
    check("rst_kind", trace_kind, 32'd0);
    check("rst_pc", trace_pc, 32'd0);
    check("rst_addr", trace_addr, 32'd0);
    check("rst_data", trace_data, 32'd0);
    check("rst_stall", stall, 32'd0);
    check("rst_done", done, 32'd0);
    reset = 1'b0;
    tick();

    // Single GRF write, visible next cycle and popped.
    drive_grf(32'h3000, 5'd8, 32'h1234_5678);
    tick();
    idle();
    check("grf1_visible", trace_valid, 32'd1);
    repeat (2) tick();

    // $0 write dropped, DM store kept.
    drive_grf(32'h3000, 5'd0, 32'h1111_1111);
    drive_dm(32'h3000, 32'h10, 32'hDEAD_BEEF);
    tick();
    idle();
    check("dm_only_kind", trace_kind, 32'd1);
    repeat (2) tick();

    // GRF and DM together: GRF first.
    drive_grf(32'h3004, 5'd3, 32'hA5A5_0003);
    drive_dm(32'h3008, 32'h20, 32'h0BAD_F00D);
    tick();
    idle();
    check("dual_first_pc", trace_pc, 32'h3004);
    repeat (3) tick();

    // Fill with trace_ready low until stall, then release; 16 events total.
    trace_ready = 1'b0;
    n = 0;
    guard = 0;
    while (n < 16 && guard < 100) begin
      drive_grf(32'h0000_0100 + 32'(n) * 32'd4, 5'(n % 31 + 1), $urandom);
      if (sbq.size() <= DEPTH - 2) n++;
      if (guard == 20) begin
        check("stall_full", stall, 32'd1);
        trace_ready = 1'b1;
      end
      tick();
      guard++;
    end
    idle();
    check("fill_bound", n, 32'd16);
    guard = 0;
    while (sbq.size() != 0 && guard < 40) begin
      tick();
      guard++;
    end
    check("fill_drained", sbq.size(), 32'd0);
    tick();

    // End-of-program trigger, drain with two events, then DONE ignores events.
    fetch_pc = 32'h0000_3FFC;
    tick();
    fetch_pc = 32'h0;
    drive_grf(32'h3FF0, 5'd9, 32'h0000_0099);
    tick();
    idle();
    drive_dm(32'h3FF4, 32'h40, 32'h0000_0044);
    tick();
    idle();
    guard = 0;
    while (mstate != 2 && guard < 30) begin
      tick();
      guard++;
    end
    tick();
    check("done_high", done, 32'd1);
    drive_grf(32'h4000, 5'd5, 32'h5555_5555);
    drive_dm(32'h4004, 32'h50, 32'h6666_6666);
    repeat (3) tick();
    idle();
    check("done_ignores", trace_valid, 32'd0);

    // Reset while in DRAIN with 3 queued entries.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    trace_ready = 1'b0;
    fetch_pc = 32'h0000_3FFC;
    tick();
    fetch_pc = 32'h0;
    drive_grf(32'h3FE0, 5'd1, 32'h0000_0001);
    drive_dm(32'h3FE4, 32'h60, 32'h0000_0002);
    tick();
    idle();
    drive_grf(32'h3FE8, 5'd2, 32'h0000_0003);
    tick();
    idle();
    check("pre_rst_queued", sbq.size(), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_rst_valid", trace_valid, 32'd0);
    check("post_rst_done", done, 32'd0);
    tick();
    trace_ready = 1'b1;
    drive_grf(32'h3100, 5'd7, 32'h7777_0007);
    tick();
    idle();
    repeat (3) tick();
    check("post_rst_run", mstate, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/retire_tracer.md
# retire_tracer

Consumer-side counterpart to the simulation bench's end-of-program check. It sits beside the pipelined `mips` datapath and captures every architectural side effect: GRF writes at W and DM stores at M. Events are queued in order in a dual-push FIFO and presented on a valid/ready trace port. The block also detects the end-of-program fetch boundary, drains in-flight work, and raises `done` so the bench or a board harness can stop cleanly.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `END_ADDR`, 32'h0000_4000: end of program; triggers when `fetch_pc + 4 >= END_ADDR`.
- `DRAIN_CYCLES`, 4: cycles after the end trigger during which in-flight instructions may still retire.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_pc` in 32: F-stage PC.
- `grf_we` in 1: W-stage register write enable.
- `grf_pc` in 32: W-stage instruction PC.
- `grf_addr` in 5: destination register.
- `grf_wd` in 32: write data.
- `dm_we` in 1: M-stage store enable.
- `dm_pc` in 32: M-stage instruction PC.
- `dm_addr` in 32: byte address.
- `dm_wd` in 32: store data.
- `trace_valid` out 1: head entry valid.
- `trace_ready` in 1: consumer accepts the head entry.
- `trace_kind` out 1: 0 = GRF, 1 = DM.
- `trace_pc` out 32: PC of the head entry.
- `trace_addr` out 32: GRF number zero-extended, or DM address.
- `trace_data` out 32: data of the head entry.
- `stall` out 1: freezes all pipeline registers.
- `done` out 1: program finished and trace drained.

## Operation
- Event qualification:
  - GRF event = `grf_we && grf_addr != 0 && !stall`.
  - DM event = `dm_we && !stall`.
- Both events may occur in one cycle. GRF (older, W) is enqueued before DM (younger, M), and both are written in the same edge.
- Entry = {kind, pc, addr, data}, 97 bits.
- `stall` = (count > DEPTH−2) and state ≠ DONE. It is decoded from the registered count only, with no combinational path from event inputs. While `stall` is high the pipeline holds, so the event is re-presented and nothing is lost or duplicated.
- Pop when `trace_valid && trace_ready`. The output is first-word-fall-through, and the head fields are stable while `trace_valid && !trace_ready`.
- Push and pop in the same cycle are legal at any occupancy; count changes by pushes − pop.
- FSM states:
  - RUN: on `fetch_pc + 4 >= END_ADDR` (32-bit unsigned add, carry discarded), load the drain counter with DRAIN_CYCLES−1 and go to DRAIN.
  - DRAIN: events are still accepted; the counter decrements each non-stalled cycle. At 0 with the FIFO empty, go to DONE.
  - DONE: new events are ignored, `done` = 1, and the state holds until `reset`.
- Reset:
  - Pointers, count and drain counter clear to 0; state = RUN.
  - `trace_valid`, `stall` and `done` = 0. `trace_kind/pc/addr/data` = 0.
  - Reset mid-operation discards queued entries.

## Timing
- Push-to-visibility latency is 1 cycle: an event sampled at edge N gives `trace_valid` = 1 after edge N.
- Pop takes effect at the edge where `trace_valid && trace_ready`; the next entry is visible in the same cycle that follows.
- Worst-case trigger-to-`done` = DRAIN_CYCLES + occupancy + stall cycles, with `trace_ready` held high.
- `stall` rises the cycle after count reaches DEPTH−1 and falls the cycle after count ≤ DEPTH−2.

## Configuration
- `RETIRE_TRACER_DISPLAY_EN`, when defined: on each pop, a simulation-only `$display` prints the entry.
  - GRF entries: `@%h: $%d <= %h`.
  - DM entries: `@%h: *%h <= %h`.
  - Always preceded by `$time`.
- Without it: no system tasks are present and the block is fully synthesizable. Port behaviour is identical either way.

## Structure
- Package `trace_pkg`:
  - `KIND_GRF` = 1'b0, `KIND_DM` = 1'b1.
  - `TRACE_W` = 97 and the entry field offsets.
  - State encoding: RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2.
- Sub-module `trace_fifo`: two write ports (port 0 ordered before port 1), one FWFT read port, and a registered count output.
- `retire_tracer` holds the qualification logic, the FSM, the drain counter and the stall decode.

## Test plan
- GRF write to $8 of 32'h1234_5678 at `grf_pc` 32'h3000, `trace_ready` = 1 → next cycle `trace_valid` = 1, kind 0, pc 32'h3000, addr 8, data 32'h1234_5678; popped after one cycle.
- GRF write to $0 plus DM store of 32'hDEAD_BEEF at address 32'h10 in the same cycle → exactly one entry is queued (DM); the $0 write is dropped.
- GRF (pc 32'h3004) and DM (pc 32'h3008) in the same cycle → two entries, GRF popped first, then DM.
- `trace_ready` = 0 with one event per cycle → `stall` = 1 once count reaches 15 with DEPTH = 16. With `trace_ready` then = 1, no entry is lost or duplicated and all 16 pop in order.
- `fetch_pc` = 32'h3FFC → DRAIN. Two events arrive within 4 cycles and are both traced, then `done` = 1 after the FIFO empties. Events after DONE are ignored.
- Assert `reset` while in DRAIN with 3 queued entries → the next cycle shows `trace_valid` = 0, `done` = 0, state RUN.
